// File: rtl/fast_ram_pkg.sv
// fast_ram_pkg
//   Shared types and constants for the fast block-RAM arbiter.
//   - ADDR_W / DATA_W : RAM port geometry (64KB, byte wide).
//   - owner_t         : which requester a pending read result belongs to.
//   - WP_*_DEFAULT    : default write-protected window (sideways-ROM image).
package fast_ram_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_SCR  = 2'd2
    } owner_t;

    localparam logic [ADDR_W-1:0] WP_LO_DEFAULT = 16'h8000;
    localparam logic [ADDR_W-1:0] WP_HI_DEFAULT = 16'hBFFF;

endpackage

// File: rtl/fast_ram_fairness_ctr.sv
// fast_ram_fairness_ctr
//   Counts consecutive CPU grants taken while the scrub side is waiting and
//   raises force_scr once MAX_CPU_RUN such grants have happened, so the scrub
//   port never waits more than MAX_CPU_RUN cycles.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     cpu_gnt    : CPU was granted this cycle
//     scr_req    : scrub side is requesting
//     scr_gnt    : scrub side was granted this cycle
//     force_scr  : scrub must win the next contended cycle
module fast_ram_fairness_ctr #(
    parameter int MAX_CPU_RUN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cpu_gnt,
    input  logic scr_req,
    input  logic scr_gnt,
    output logic force_scr
);

    localparam int CNT_W = $clog2(MAX_CPU_RUN + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_CPU_RUN);

    logic [CNT_W-1:0] run_cnt;

    assign force_scr = (run_cnt == RUN_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (!scr_req || scr_gnt) begin
            // No one is starving (or the starving side just got its slot).
            run_cnt <= '0;
        end else if (cpu_gnt && run_cnt != RUN_MAX) begin
            run_cnt <= run_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fast_ram_arbiter.sv
// fast_ram_arbiter
//   Shares the single 64KB fast block-RAM port between the CPU (primary) and
//   the scrub/loader engine (secondary). CPU has fixed priority, bounded by a
//   fairness counter; CPU writes into [WP_LO, WP_HI] can be dropped when
//   wp_en is set.
//   Ports:
//     cpu_clk, Res_n                      : clock, async active-low reset
//     cpu_req/we/A/D_wr -> cpu_gnt        : CPU request side
//     cpu_D_rd, cpu_rvalid                : CPU read return (1 cycle latency)
//     scr_req/we/A/D_wr -> scr_gnt        : scrub request side
//     scr_D_rd, scr_rvalid                : scrub read return
//     wp_en, wp_hit                       : protection enable / drop pulse
//     ram_A, ram_we, ram_D_wr, ram_D_rd   : RAM port (synchronous read)
//
//   Handshake: a requester holds req/we/A/D_wr stable until it sees gnt=1 on
//   a rising edge; the access happens in that grant cycle, and req may stay
//   high for back-to-back accesses. gnt is combinational from req.
module fast_ram_arbiter
    import fast_ram_pkg::*;
#(
    parameter int                MAX_CPU_RUN = 8,
    parameter logic [ADDR_W-1:0] WP_LO       = WP_LO_DEFAULT,
    parameter logic [ADDR_W-1:0] WP_HI       = WP_HI_DEFAULT
) (
    input  logic              cpu_clk,
    input  logic              Res_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_A,
    input  logic [DATA_W-1:0] cpu_D_wr,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_D_rd,
    output logic              cpu_rvalid,
    input  logic              scr_req,
    input  logic              scr_we,
    input  logic [ADDR_W-1:0] scr_A,
    input  logic [DATA_W-1:0] scr_D_wr,
    output logic              scr_gnt,
    output logic [DATA_W-1:0] scr_D_rd,
    output logic              scr_rvalid,
    input  logic              wp_en,
    output logic              wp_hit,
    output logic [ADDR_W-1:0] ram_A,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_D_wr,
    input  logic [DATA_W-1:0] ram_D_rd
);

    logic              force_scr;
    logic              scr_pick;
    logic              wp_block;
    owner_t            owner;
    logic [DATA_W-1:0] cpu_d_hold;
    logic [DATA_W-1:0] scr_d_hold;

    fast_ram_fairness_ctr #(
        .MAX_CPU_RUN(MAX_CPU_RUN)
    ) u_fairness (
        .clk      (cpu_clk),
        .rst_n    (Res_n),
        .cpu_gnt  (cpu_gnt),
        .scr_req  (scr_req),
        .scr_gnt  (scr_gnt),
        .force_scr(force_scr)
    );

    always_comb begin
        wp_block = wp_en && cpu_we && (cpu_A >= WP_LO) && (cpu_A <= WP_HI);
        // Scrub wins when uncontended, or when the CPU has used up its run.
        scr_pick = scr_req && (!cpu_req || force_scr);
        // Grants and write enable are gated by Res_n so no access, and in
        // particular no partial write, can leak out while reset is held.
        cpu_gnt  = Res_n && cpu_req && !scr_pick;
        scr_gnt  = Res_n && scr_pick;

        // With no grant the CPU address is presented as a lookahead.
        ram_A    = cpu_A;
        ram_D_wr = cpu_D_wr;
        ram_we   = 1'b0;
        if (scr_gnt) begin
            ram_A    = scr_A;
            ram_D_wr = scr_D_wr;
            ram_we   = scr_we;
        end else if (cpu_gnt) begin
            ram_we   = cpu_we && !wp_block;
        end
    end

    // Owner of the read result returning next cycle; writes leave it NONE.
    always_ff @(posedge cpu_clk or negedge Res_n) begin
        if (!Res_n) begin
            owner  <= OWN_NONE;
            wp_hit <= 1'b0;
        end else begin
            wp_hit <= cpu_gnt && wp_block;
            if (cpu_gnt && !cpu_we) begin
                owner <= OWN_CPU;
            end else if (scr_gnt && !scr_we) begin
                owner <= OWN_SCR;
            end else begin
                owner <= OWN_NONE;
            end
        end
    end

    assign cpu_rvalid = (owner == OWN_CPU);
    assign scr_rvalid = (owner == OWN_SCR);

    // D_rd forwards the RAM output in the rvalid cycle and holds it after.
    always_ff @(posedge cpu_clk or negedge Res_n) begin
        if (!Res_n) begin
            cpu_d_hold <= '0;
            scr_d_hold <= '0;
        end else begin
            if (cpu_rvalid) cpu_d_hold <= ram_D_rd;
            if (scr_rvalid) scr_d_hold <= ram_D_rd;
        end
    end

    assign cpu_D_rd = cpu_rvalid ? ram_D_rd : cpu_d_hold;
    assign scr_D_rd = scr_rvalid ? ram_D_rd : scr_d_hold;

endmodule
